mem_burst_reader: RTL

Read-side initiator for the single-port input memory used by the DCNN IO path. It takes a base address and word count, and issues one read request at a time on the memory's level-request / done handshake. Each returned word is presented on a valid/ready stream toward the feature/filter loaders. This block is the requester that drives read_signal/address and consumes dataout/doneRead of the memory.

---
 rtl/mem_io_pkg.sv | 25 ++
 rtl/mem_rd_timer.sv | 43 ++++
 rtl/mem_burst_reader.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/mem_io_pkg.sv
// -----------------------------------------------------------------------------
// mem_io_pkg
// Shared definitions for the DCNN IO memory read path.
//   - state_t          : burst reader FSM states
//   - DEF_ADDR_W       : default memory address width
//   - DEF_DATA_W       : default memory word width
//   - DEF_LEN_W        : default burst length counter width
//   - DEF_TIMEOUT_CYC  : default read-completion timeout (MEM_TIMEOUT_EN builds)
// -----------------------------------------------------------------------------
package mem_io_pkg;

  localparam int DEF_ADDR_W      = 16;
  localparam int DEF_DATA_W      = 16;
  localparam int DEF_LEN_W       = 16;
  localparam int DEF_TIMEOUT_CYC = 256;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_PUSH,
    ST_FIN
  } state_t;

endpackage

// File: rtl/mem_rd_timer.sv
// -----------------------------------------------------------------------------
// mem_rd_timer
// Counts cycles spent waiting for a memory read completion. Used by
// mem_burst_reader only when MEM_TIMEOUT_EN is defined.
//
// Ports:
//   clk        : clock, posedge
//   RST        : asynchronous active-low reset
//   i_clear    : synchronous clear (asserted the cycle before waiting starts)
//   i_enable   : count this cycle (high while waiting)
//   o_expired  : high during the LIMIT-th enabled cycle since the last clear
// -----------------------------------------------------------------------------
module mem_rd_timer
  import mem_io_pkg::*;
#(
  parameter int LIMIT = DEF_TIMEOUT_CYC
) (
  input  logic clk,
  input  logic RST,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);

  localparam int CNT_W = $clog2(LIMIT + 1);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      r_cnt <= '0;
    end else if (i_clear) begin
      r_cnt <= '0;
    end else if (i_enable) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  // The count lags the enabled cycles by one, so LIMIT-1 marks the LIMIT-th
  // waiting cycle; the owner leaves the wait state on the following edge.
  assign o_expired = i_enable && (r_cnt == CNT_W'(LIMIT - 1));

endmodule

// File: rtl/mem_burst_reader.sv
// -----------------------------------------------------------------------------
// mem_burst_reader
// Read-side initiator for the single-port DCNN input memory. Accepts a base
// address and a word count, reads the words one at a time over the memory's
// level-request / done-strobe handshake, and presents each word on a
// valid/ready stream.
//
// Build option: MEM_TIMEOUT_EN -- when defined, a read that sees no
// mem_rd_done for TIMEOUT_CYC waiting cycles ends the burst with err+done.
//
// Ports:
//   clk, RST         : clock (posedge), asynchronous active-low reset
//   start, abort     : burst start pulse (IDLE only), synchronous abort
//   base_addr, length: burst description, sampled on accepted start
//   mem_address      : read address to memory
//   mem_read_signal  : read request level, held until mem_rd_done
//   mem_dataout      : memory read data, valid with mem_rd_done
//   mem_rd_done      : single-cycle read completion strobe
//   out_valid/ready  : output stream handshake
//   out_data/last    : output word and end-of-burst marker
//   busy, done, err  : status (done/err are one-cycle pulses)
// -----------------------------------------------------------------------------
module mem_burst_reader
  import mem_io_pkg::*;
#(
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int DATA_W      = DEF_DATA_W,
  parameter int LEN_W       = DEF_LEN_W,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic              clk,
  input  logic              RST,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [LEN_W-1:0]  length,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_read_signal,
  input  logic [DATA_W-1:0] mem_dataout,
  input  logic              mem_rd_done,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              busy,
  output logic              done,
  output logic              err
);

  state_t            r_state;
  state_t            w_next;
  logic [ADDR_W-1:0] r_addr;
  logic [LEN_W-1:0]  r_len;
  logic [LEN_W-1:0]  r_idx;
  logic [DATA_W-1:0] r_data;
  logic              w_last;
  logic              w_beat;
  logic              w_timeout;

  assign w_last = (r_idx == r_len - LEN_W'(1));
  assign w_beat = (r_state == ST_PUSH) && out_ready;

`ifdef MEM_TIMEOUT_EN
  logic w_expired;
  logic r_err;

  mem_rd_timer #(
    .LIMIT (TIMEOUT_CYC)
  ) u_timer (
    .clk       (clk),
    .RST       (RST),
    .i_clear   (r_state == ST_REQ),
    .i_enable  (r_state == ST_WAIT),
    .o_expired (w_expired)
  );

  assign w_timeout = w_expired;

  // Remembers that the burst is ending by timeout so err lines up with done.
  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      r_err <= 1'b0;
    end else begin
      r_err <= (r_state == ST_WAIT) && w_expired && !mem_rd_done && !abort;
    end
  end

  assign err = (r_state == ST_FIN) && r_err;
`else
  assign w_timeout = 1'b0;
  assign err       = 1'b0;
`endif

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // NOTE: w_next gets its default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (start) w_next = (length == '0) ? ST_FIN : ST_REQ;
      ST_REQ:  w_next = ST_WAIT;
      ST_WAIT: begin
        if (mem_rd_done)    w_next = ST_PUSH;
        else if (w_timeout) w_next = ST_FIN;
      end
      ST_PUSH: if (out_ready) w_next = w_last ? ST_FIN : ST_REQ;
      ST_FIN:  w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
    // Abort overrides everything; FIN already pulses done, so it still exits.
    if (abort && (r_state != ST_IDLE) && (r_state != ST_FIN)) w_next = ST_FIN;
  end

  // r_addr tracks base+idx directly; ADDR_W-bit increment gives the wrap.
  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      r_addr <= '0;
      r_len  <= '0;
      r_idx  <= '0;
      r_data <= '0;
    end else begin
      if ((r_state == ST_IDLE) && start) begin
        r_addr <= base_addr;
        r_len  <= length;
        r_idx  <= '0;
      end
      if ((r_state == ST_WAIT) && mem_rd_done && !abort) begin
        r_data <= mem_dataout;
      end
      if (w_beat && !w_last && !abort) begin
        r_idx  <= r_idx + LEN_W'(1);
        r_addr <= r_addr + ADDR_W'(1);
      end
    end
  end

  assign mem_address     = r_addr;
  assign mem_read_signal = (r_state == ST_REQ) || (r_state == ST_WAIT);
  assign out_valid       = (r_state == ST_PUSH);
  assign out_last        = (r_state == ST_PUSH) && w_last;
  assign out_data        = r_data;
  assign busy            = (r_state != ST_IDLE);
  assign done            = (r_state == ST_FIN);

endmodule
